pipe_ctrl_unit: RTL and testbench

- Next-generation control unit for the 3-stage RV32 pipeline; replaces the purely combinational decoder.
- Decodes the instruction in the fetch/decode stage and registers the control bundle into the execute/writeback stage.
- Generates pipeline stall (PCen) and flush bubbles.
- Sequences an optional multi-cycle M-extension unit (MUL/DIV) with a latency-counting FSM.

---
 rtl/pipe_ctrl_unit.sv | 271 +++++++++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit for the 3-stage RV32 core. It registers the decoded control
// bundle into execute/writeback, generates stalls and flush bubbles, and sequences the MDU.

package pipe_ctrl_pkg;
    typedef enum logic [3:0] {
        alu_add  = 4'd0,
        alu_sub  = 4'd1,
        alu_sll  = 4'd2,
        alu_slt  = 4'd3,
        alu_sltu = 4'd4,
        alu_xor  = 4'd5,
        alu_srl  = 4'd6,
        alu_sra  = 4'd7,
        alu_or   = 4'd8,
        alu_and  = 4'd9
    } type_alu;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        type_alu    alu_op;
        logic       reg_write;
        logic       read_en;
        logic       write_en;
        logic [1:0] wb_sel;
        logic [1:0] br_type;
        logic       sel_a;
        logic       sel_b;
        logic       zero_a;
    } ctrl_t;

    localparam logic [1:0] WB_MEM  = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_MDU  = 2'b11;
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_COND = 2'b01;
    localparam logic [1:0] BR_JUMP = 2'b10;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // The bubble doubles as the reset bundle: nothing is written, operand A is rs1.
    localparam ctrl_t CTRL_BUBBLE = '{
        alu_op: alu_add, reg_write: 1'b0, read_en: 1'b0, write_en: 1'b0,
        wb_sel: WB_MEM, br_type: BR_NONE, sel_a: 1'b1, sel_b: 1'b0, zero_a: 1'b0
    };

    localparam ctrl_t CTRL_MD_WB = '{
        alu_op: alu_add, reg_write: 1'b1, read_en: 1'b0, write_en: 1'b0,
        wb_sel: WB_MDU, br_type: BR_NONE, sel_a: 1'b1, sel_b: 1'b0, zero_a: 1'b0
    };
endpackage

module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter bit MDU_EN  = 1'b1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [6:0] opcode_in,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       br_taken,
    output logic [3:0] alu_op,
    output logic       reg_write,
    output logic       read_en,
    output logic       write_en,
    output logic [1:0] wb_sel,
    output logic [1:0] br_type,
    output logic       sel_A,
    output logic       sel_B,
    output logic       zero_A,
    output logic       md_start,
    output logic [2:0] md_op,
    output logic       PCen,
    output logic       illegal
);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             md_start_q, md_start_d;
    logic [2:0]       md_op_q, md_op_d;
    logic             illegal_q, illegal_d;

    ctrl_t            dec_ctrl;
    logic             dec_illegal;
    logic             dec_mop;
    logic [CNT_W-1:0] md_lat;
    logic             busy;
    logic             md_done;
    logic             decode_en;
    logic             squash;

    // Pure field decode; sequencing and squashing decide later whether it is used.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        dec_ctrl    = CTRL_BUBBLE;
        dec_illegal = 1'b0;
        dec_mop     = 1'b0;
        case (opcode_in)
            OP_R: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.wb_sel    = WB_ALU;
                dec_ctrl.sel_b     = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  dec_ctrl.alu_op = alu_add;
                            3'b001:  dec_ctrl.alu_op = alu_sll;
                            3'b010:  dec_ctrl.alu_op = alu_slt;
                            3'b011:  dec_ctrl.alu_op = alu_sltu;
                            3'b100:  dec_ctrl.alu_op = alu_xor;
                            3'b101:  dec_ctrl.alu_op = alu_srl;
                            3'b110:  dec_ctrl.alu_op = alu_or;
                            default: dec_ctrl.alu_op = alu_and;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000)      dec_ctrl.alu_op = alu_sub;
                        else if (funct3 == 3'b101) dec_ctrl.alu_op = alu_sra;
                        else                       dec_illegal     = 1'b1;
                    end
                    7'b0000001: begin
                        if (MDU_EN) dec_mop     = 1'b1;
                        else        dec_illegal = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.wb_sel    = WB_ALU;
                case (funct3)
                    3'b000:  dec_ctrl.alu_op = alu_add;
                    3'b001:  dec_ctrl.alu_op = alu_sll;
                    3'b010:  dec_ctrl.alu_op = alu_slt;
                    3'b011:  dec_ctrl.alu_op = alu_sltu;
                    3'b100:  dec_ctrl.alu_op = alu_xor;
                    3'b110:  dec_ctrl.alu_op = alu_or;
                    3'b111:  dec_ctrl.alu_op = alu_and;
                    default: dec_ctrl.alu_op = funct7[5] ? alu_sra : alu_srl;
                endcase
            end
            OP_LOAD: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.read_en   = 1'b1;
                dec_ctrl.wb_sel    = WB_MEM;
            end
            OP_STORE: dec_ctrl.write_en = 1'b1;
            OP_BRANCH: begin
                dec_ctrl.br_type = BR_COND;
                dec_ctrl.sel_a   = 1'b0;
            end
            OP_AUIPC: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.wb_sel    = WB_ALU;
                dec_ctrl.sel_a     = 1'b0;
            end
            OP_LUI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.wb_sel    = WB_ALU;
                dec_ctrl.zero_a    = 1'b1;
            end
            OP_JAL: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.wb_sel    = WB_PC4;
                dec_ctrl.br_type   = BR_JUMP;
                dec_ctrl.sel_a     = 1'b0;
            end
            OP_JALR: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.wb_sel    = WB_PC4;
                dec_ctrl.br_type   = BR_JUMP;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign md_lat    = funct3[2] ? DIV_CNT : MUL_CNT;
    assign busy      = (state_q == MD_BUSY);
    assign md_done   = busy && (cnt_q == '0);
    // The last busy cycle releases the front end, so decode runs again in it.
    assign decode_en = !busy || md_done;
    // The MD op occupies execute while busy, so any redirect then is not ours.
    assign squash    = br_taken && !busy;
    assign PCen      = decode_en;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctrl_d     = CTRL_BUBBLE;
        md_start_d = 1'b0;
        md_op_d    = md_op_q;
        illegal_d  = 1'b0;

        if (busy) begin
            if (md_done) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            // Writeback is registered so it is visible during the final busy cycle.
            if (cnt_q == CNT_W'(1)) ctrl_d = CTRL_MD_WB;
        end

        if (decode_en && instr_valid && !squash) begin
            if (dec_illegal) begin
                illegal_d = 1'b1;
            end else if (dec_mop) begin
                md_start_d = 1'b1;
                md_op_d    = funct3;
                cnt_d      = md_lat;
                state_d    = MD_BUSY;
                if (md_lat == '0) ctrl_d = CTRL_MD_WB;
            end else begin
                ctrl_d = dec_ctrl;
            end
        end
    end

    // NOTE: state uses non-blocking assignments and a synchronous reset sampled on clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ctrl_q     <= CTRL_BUBBLE;
            md_start_q <= 1'b0;
            md_op_q    <= 3'b000;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ctrl_q     <= ctrl_d;
            md_start_q <= md_start_d;
            md_op_q    <= md_op_d;
            illegal_q  <= illegal_d;
        end
    end

    assign alu_op    = ctrl_q.alu_op;
    assign reg_write = ctrl_q.reg_write;
    assign read_en   = ctrl_q.read_en;
    assign write_en  = ctrl_q.write_en;
    assign wb_sel    = ctrl_q.wb_sel;
    assign br_type   = ctrl_q.br_type;
    assign sel_A     = ctrl_q.sel_a;
    assign sel_B     = ctrl_q.sel_b;
    assign zero_A    = ctrl_q.zero_a;
    assign md_start  = md_start_q;
    assign md_op     = md_op_q;
    assign illegal   = illegal_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: each driven cycle queues the bundle expected
// after the next edge, plus a second MDU-less instance for the illegal-M case.

module tb_pipe_ctrl_unit;
    import pipe_ctrl_pkg::*;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] I_OP   = 7'b0010011;
    localparam logic [6:0] LD_OP  = 7'b0000011;
    localparam logic [6:0] ST_OP  = 7'b0100011;
    localparam logic [6:0] BR_OP  = 7'b1100011;
    localparam logic [6:0] AUI_OP = 7'b0010111;
    localparam logic [6:0] LUI_OP = 7'b0110111;
    localparam logic [6:0] JAL_OP = 7'b1101111;
    localparam logic [6:0] JLR_OP = 7'b1100111;
    localparam logic [6:0] BAD_OP = 7'b1111111;
    localparam logic [6:0] F7_M   = 7'b0000001;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef struct packed {
        logic [3:0] alu;
        logic       rw;
        logic       rd;
        logic       wr;
        logic [1:0] wb;
        logic [1:0] br;
        logic       sa;
        logic       sb;
        logic       za;
        logic       ms;
        logic [2:0] mop;
        logic       ill;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic [6:0] opcode_in;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       br_taken;

    logic [3:0] alu_op;
    logic       reg_write, read_en, write_en;
    logic [1:0] wb_sel, br_type;
    logic       sel_A, sel_B, zero_A, md_start, PCen, illegal;
    logic [2:0] md_op;

    logic [3:0] nm_alu_op;
    logic       nm_reg_write, nm_read_en, nm_write_en;
    logic [1:0] nm_wb_sel, nm_br_type;
    logic       nm_sel_A, nm_sel_B, nm_zero_A, nm_md_start, nm_pcen, nm_illegal;
    logic [2:0] nm_md_op;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] last_mop = 3'b000;
    exp_t       exp_q[$];
    string      tag_q[$];

    pipe_ctrl_unit #(.MDU_EN(1'b1), .MUL_LAT(2), .DIV_LAT(32), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode_in(opcode_in),
        .funct3(funct3), .funct7(funct7), .br_taken(br_taken),
        .alu_op(alu_op), .reg_write(reg_write), .read_en(read_en), .write_en(write_en),
        .wb_sel(wb_sel), .br_type(br_type), .sel_A(sel_A), .sel_B(sel_B), .zero_A(zero_A),
        .md_start(md_start), .md_op(md_op), .PCen(PCen), .illegal(illegal)
    );

    pipe_ctrl_unit #(.MDU_EN(1'b0), .MUL_LAT(2), .DIV_LAT(32), .CNT_W(8)) u_dut_nomdu (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode_in(opcode_in),
        .funct3(funct3), .funct7(funct7), .br_taken(br_taken),
        .alu_op(nm_alu_op), .reg_write(nm_reg_write), .read_en(nm_read_en),
        .write_en(nm_write_en), .wb_sel(nm_wb_sel), .br_type(nm_br_type),
        .sel_A(nm_sel_A), .sel_B(nm_sel_B), .zero_A(nm_zero_A), .md_start(nm_md_start),
        .md_op(nm_md_op), .PCen(nm_pcen), .illegal(nm_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] alu, input logic rw, input logic rd,
                                input logic wr, input logic [1:0] wb, input logic [1:0] br,
                                input logic sa, input logic sb, input logic za);
        exp_t e;
        e = '{alu: alu, rw: rw, rd: rd, wr: wr, wb: wb, br: br, sa: sa, sb: sb, za: za,
              ms: 1'b0, mop: last_mop, ill: 1'b0};
        return e;
    endfunction

    function automatic exp_t bubble();
        return mk(alu_add, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    endfunction

    function automatic exp_t ill_exp();
        exp_t e;
        e     = bubble();
        e.ill = 1'b1;
        return e;
    endfunction

    function automatic exp_t md_start_exp();
        exp_t e;
        e    = bubble();
        e.ms = 1'b1;
        return e;
    endfunction

    function automatic exp_t md_wb_exp();
        return mk(alu_add, 1, 0, 0, 2'b11, 2'b00, 1, 0, 0);
    endfunction

    function automatic exp_t add_exp();
        return mk(alu_add, 1, 0, 0, 2'b01, 2'b00, 1, 1, 0);
    endfunction

    task automatic compare_next();
        logic [18:0] got;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end else begin
            got = {alu_op, reg_write, read_en, write_en, wb_sel, br_type,
                   sel_A, sel_B, zero_A, md_start, md_op, illegal};
            check(tag_q.pop_front(), 32'(got), 32'(exp_q.pop_front()));
        end
    endtask

    // Called just after a rising edge: drive one decode cycle, check PCen in it,
    // queue the bundle expected after the edge, then compare once it is out.
    task automatic step(input string tag, input logic v, input logic [6:0] op,
                        input logic [2:0] f3, input logic [6:0] f7, input logic br,
                        input exp_t e, input logic pcen_e);
        instr_valid = v;
        opcode_in   = op;
        funct3      = f3;
        funct7      = f7;
        br_taken    = br;
        #1;
        check({tag, "_pcen"}, 32'(PCen), 32'(pcen_e));
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        compare_next();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected end of test earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] got;
        rst         = 1'b1;
        instr_valid = 1'b0;
        opcode_in   = 7'd0;
        funct3      = 3'd0;
        funct7      = 7'd0;
        br_taken    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = {alu_op, reg_write, read_en, write_en, wb_sel, br_type,
               sel_A, sel_B, zero_A, md_start, md_op, illegal};
        check("reset_bundle", 32'(got), 32'(bubble()));
        check("reset_pcen", 32'(PCen), 32'd1);
        rst = 1'b0;

        // Plain RV32I decode
        step("add",    1, R_OP,   3'b000, 7'h00,  0, add_exp(), 1);
        step("lui",    1, LUI_OP, 3'b101, 7'h09,  0, mk(alu_add, 1, 0, 0, 2'b01, 2'b00, 1, 0, 1), 1);
        step("srai",   1, I_OP,   3'b101, F7_ALT, 0, mk(alu_sra, 1, 0, 0, 2'b01, 2'b00, 1, 0, 0), 1);
        step("srli",   1, I_OP,   3'b101, 7'h00,  0, mk(alu_srl, 1, 0, 0, 2'b01, 2'b00, 1, 0, 0), 1);
        step("sub",    1, R_OP,   3'b000, F7_ALT, 0, mk(alu_sub, 1, 0, 0, 2'b01, 2'b00, 1, 1, 0), 1);
        step("and",    1, R_OP,   3'b111, 7'h00,  0, mk(alu_and, 1, 0, 0, 2'b01, 2'b00, 1, 1, 0), 1);
        step("load",   1, LD_OP,  3'b010, 7'h00,  0, mk(alu_add, 1, 1, 0, 2'b00, 2'b00, 1, 0, 0), 1);
        step("store",  1, ST_OP,  3'b010, 7'h00,  0, mk(alu_add, 0, 0, 1, 2'b00, 2'b00, 1, 0, 0), 1);
        step("branch", 1, BR_OP,  3'b000, 7'h00,  0, mk(alu_add, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0), 1);
        step("auipc",  1, AUI_OP, 3'b000, 7'h00,  0, mk(alu_add, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0), 1);
        step("jal",    1, JAL_OP, 3'b000, 7'h00,  0, mk(alu_add, 1, 0, 0, 2'b10, 2'b10, 0, 0, 0), 1);
        step("jalr",   1, JLR_OP, 3'b000, 7'h00,  0, mk(alu_add, 1, 0, 0, 2'b10, 2'b10, 1, 0, 0), 1);
        step("invalid", 0, R_OP,  3'b000, 7'h00,  0, bubble(), 1);

        // Illegal encodings: one-cycle flag plus bubble
        step("ill_op",    1, BAD_OP, 3'b000, 7'h00,  0, ill_exp(), 1);
        step("after_ill", 1, R_OP,   3'b000, 7'h00,  0, add_exp(), 1);
        step("ill_rfunc", 1, R_OP,   3'b001, F7_ALT, 0, ill_exp(), 1);

        // Redirect squashes decode, beating illegal and M-op start
        step("br_load",  1, LD_OP,  3'b010, 7'h00, 1, bubble(), 1);
        step("br_ill",   1, BAD_OP, 3'b000, 7'h00, 1, bubble(), 1);
        step("br_mul",   1, R_OP,   3'b000, F7_M,  1, bubble(), 1);
        step("post_br",  1, R_OP,   3'b000, 7'h00, 0, add_exp(), 1);

        // DIV: 32 busy cycles, writeback visible in the last one, redirect ignored
        last_mop = 3'b100;
        step("div_start", 1, R_OP, 3'b100, F7_M, 0, md_start_exp(), 1);
        for (int k = 1; k <= 31; k++) begin
            step((k == 31) ? "div_wb" : "div_busy", 1, R_OP, 3'b000, F7_M, (k == 3),
                 (k == 31) ? md_wb_exp() : bubble(), 0);
        end
        last_mop = 3'b000;
        step("mul_start", 1, R_OP, 3'b000, F7_M, 0, md_start_exp(), 1);
        check("nomdu_mul_illegal", 32'(nm_illegal), 32'd1);
        check("nomdu_mul_start", 32'(nm_md_start), 32'd0);
        check("nomdu_mul_pcen", 32'(nm_pcen), 32'd1);
        step("mul_wb",    1, R_OP, 3'b000, 7'h00, 0, md_wb_exp(), 0);
        step("mul_next",  1, R_OP, 3'b000, 7'h00, 0, add_exp(), 1);
        step("idle",      0, R_OP, 3'b000, 7'h00, 0, bubble(), 1);

        // Reset on the 5th busy cycle of a DIV aborts without writeback
        last_mop = 3'b101;
        step("div2_start", 1, R_OP, 3'b101, F7_M, 0, md_start_exp(), 1);
        for (int k = 1; k <= 4; k++) begin
            step("div2_busy", 1, R_OP, 3'b000, 7'h00, 0, bubble(), 0);
        end
        rst      = 1'b1;
        last_mop = 3'b000;
        step("div2_rst", 1, R_OP, 3'b000, 7'h00, 0, bubble(), 0);
        rst = 1'b0;
        step("post_rst_add", 1, R_OP, 3'b000, 7'h00, 0, add_exp(), 1);
        for (int k = 0; k < 3; k++) begin
            step("post_rst_idle", 0, R_OP, 3'b000, 7'h00, 0, bubble(), 1);
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
